// File: rtl/tg_csr_pkg.sv
// rtl/tg_csr_pkg.sv - shared types and constants for the memory traffic-generator CSR and run control
package tg_csr_pkg;

    localparam int M_CHANNEL = 4;
    localparam logic [31:0] TG_TIMEOUT_DEFAULT = 32'd100000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } t_tg_chan_state;

    typedef struct packed {
        logic pass;
        logic fail;
        logic timeout;
        logic active;
    } t_tg_stat;

    typedef struct packed {
        logic [M_CHANNEL-1:0] init_n;
    } t_tg_ctrl;

endpackage

// File: rtl/mem_tg_chan_fsm.sv
// rtl/mem_tg_chan_fsm.sv - one channel's launch/handshake FSM, watchdog counter and status flops
module mem_tg_chan_fsm
    import tg_csr_pkg::*;
#(
    parameter int unsigned        TO_W           = 32,
    parameter logic [TO_W-1:0]    TIMEOUT_CYCLES = TG_TIMEOUT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_launch,
    input  logic       i_ready,
    input  logic       i_done,
    input  logic       i_fail,
    output logic       o_start,
    output logic       o_abort,
    output logic [3:0] o_stat
);

    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYCLES - {{(TO_W-1){1'b0}}, 1'b1};

    t_tg_chan_state  r_state, w_state_nxt;
    logic [TO_W-1:0] r_cnt, w_cnt_nxt;
    logic            r_pass, r_fail, r_timeout, r_abort;
    logic            w_pass_nxt, w_fail_nxt, w_timeout_nxt, w_abort_nxt;
    logic            w_running;
    logic            w_to_hit;
    t_tg_stat        w_stat;

    assign w_running = (r_state == ST_START) || (r_state == ST_RUN);
    assign w_to_hit  = (TIMEOUT_CYCLES != '0) && (r_cnt == TO_LAST) && w_running;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pass    <= w_pass_nxt;
            r_fail    <= w_fail_nxt;
            r_timeout <= w_timeout_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pass_nxt    = r_pass;
        w_fail_nxt    = r_fail;
        w_timeout_nxt = r_timeout;
        w_abort_nxt   = 1'b0;

        // Saturating: with the watchdog disabled a long run must not wrap back through zero.
        if (w_running && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_launch) begin
                    w_state_nxt   = ST_START;
                    w_cnt_nxt     = '0;
                    w_pass_nxt    = 1'b0;
                    w_fail_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                end
            end
            ST_START: begin
                if (w_to_hit) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_nxt = 1'b1;
                    w_abort_nxt   = 1'b1;
                end else if (i_ready) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A completion landing on the deadline cycle still counts as a real result.
                if (i_done) begin
                    w_state_nxt = ST_DONE;
                    w_pass_nxt  = ~i_fail;
                    w_fail_nxt  = i_fail;
                end else if (w_to_hit) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_nxt = 1'b1;
                    w_abort_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_stat.pass    = r_pass;
    assign w_stat.fail    = r_fail;
    assign w_stat.timeout = r_timeout;
    assign w_stat.active  = w_running;

    assign o_start = (r_state == ST_START);
    assign o_abort = r_abort;
    assign o_stat  = w_stat;

endmodule

// File: rtl/mem_tg_chan_ctrl.sv
// rtl/mem_tg_chan_ctrl.sv - per-channel run controller between the TG CSR block and the TG cores
module mem_tg_chan_ctrl
    import tg_csr_pkg::*;
#(
    parameter int unsigned     M_CHANNEL      = tg_csr_pkg::M_CHANNEL,
    parameter int unsigned     TO_W           = 32,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TG_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   csr_ctrl_wr,
    input  logic [M_CHANNEL-1:0]   csr_ctrl_init_n,
    output logic [M_CHANNEL-1:0]   tg_start,
    input  logic [M_CHANNEL-1:0]   tg_ready,
    input  logic [M_CHANNEL-1:0]   tg_done,
    input  logic [M_CHANNEL-1:0]   tg_fail,
    output logic [M_CHANNEL-1:0]   tg_abort,
    output logic [4*M_CHANNEL-1:0] csr_tg_stat
);

    logic [M_CHANNEL-1:0] w_launch;

    // init_n is active-low: a 0 bit requests a run on that channel.
    assign w_launch = {M_CHANNEL{csr_ctrl_wr}} & ~csr_ctrl_init_n;

    for (genvar g = 0; g < M_CHANNEL; g++) begin : g_chan
        logic [3:0] w_stat;

        mem_tg_chan_fsm #(
            .TO_W           (TO_W),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_chan (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_launch (w_launch[g]),
            .i_ready  (tg_ready[g]),
            .i_done   (tg_done[g]),
            .i_fail   (tg_fail[g]),
            .o_start  (tg_start[g]),
            .o_abort  (tg_abort[g]),
            .o_stat   (w_stat)
        );

        assign csr_tg_stat[4*g +: 4] = w_stat;
    end

endmodule

// File: tb/tb_mem_tg_chan_ctrl.sv
// tb/tb_mem_tg_chan_ctrl.sv - self-checking bench for mem_tg_chan_ctrl against a per-channel run model
module tb_mem_tg_chan_ctrl;

    localparam int NCH = 4;
    localparam int TO  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             csr_ctrl_wr;
    logic [NCH-1:0]   csr_ctrl_init_n;
    logic [NCH-1:0]   tg_ready;
    logic [NCH-1:0]   tg_done;
    logic [NCH-1:0]   tg_fail;
    logic [NCH-1:0]   tg_start;
    logic [NCH-1:0]   tg_abort;
    logic [4*NCH-1:0] csr_tg_stat;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a run is "busy" from launch until it resolves; "age" is edges spent busy.
    bit m_busy [NCH];
    bit m_acc  [NCH];
    bit m_pass [NCH];
    bit m_fl   [NCH];
    bit m_to   [NCH];
    bit m_ab   [NCH];
    int m_age  [NCH];

    always #5 clk = ~clk;

    mem_tg_chan_ctrl #(
        .M_CHANNEL      (NCH),
        .TO_W           (32),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .csr_ctrl_wr     (csr_ctrl_wr),
        .csr_ctrl_init_n (csr_ctrl_init_n),
        .tg_start        (tg_start),
        .tg_ready        (tg_ready),
        .tg_done         (tg_done),
        .tg_fail         (tg_fail),
        .tg_abort        (tg_abort),
        .csr_tg_stat     (csr_tg_stat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            m_ab[i] = 1'b0;
            if (!rst_n) begin
                m_busy[i] = 0; m_acc[i] = 0; m_pass[i] = 0;
                m_fl[i] = 0; m_to[i] = 0; m_age[i] = 0;
            end else if (m_busy[i]) begin
                if (m_acc[i] && tg_done[i]) begin
                    m_busy[i] = 0;
                    m_pass[i] = !tg_fail[i];
                    m_fl[i]   = tg_fail[i];
                end else if (m_age[i] + 1 >= TO) begin
                    m_busy[i] = 0;
                    m_to[i]   = 1;
                    m_ab[i]   = 1;
                end else if (!m_acc[i] && tg_ready[i]) begin
                    m_acc[i] = 1;
                end
                m_age[i]++;
            end else if (csr_ctrl_wr && !csr_ctrl_init_n[i]) begin
                m_busy[i] = 1; m_acc[i] = 0; m_age[i] = 0;
                m_pass[i] = 0; m_fl[i] = 0; m_to[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("start[%0d]", i), 32'(tg_start[i]), 32'(m_busy[i] && !m_acc[i]));
            chk($sformatf("abort[%0d]", i), 32'(tg_abort[i]), 32'(m_ab[i]));
            chk($sformatf("stat[%0d]", i), 32'(csr_tg_stat[4*i +: 4]),
                32'({m_pass[i], m_fl[i], m_to[i], m_busy[i]}));
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [NCH-1:0] in_n,
                        input logic [NCH-1:0] rdy, input logic [NCH-1:0] dn,
                        input logic [NCH-1:0] fl);
        rst_n           = r;
        csr_ctrl_wr     = w;
        csr_ctrl_init_n = in_n;
        tg_ready        = rdy;
        tg_done         = dn;
        tg_fail         = fl;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, '1, '0, '0, '0);
    endtask

    int cnt;
    int ab_cnt;
    int ab_at;

    initial begin
        step(0, 0, '1, '0, '0, '0);
        step(0, 0, '1, '0, '0, '0);
        chk("reset_stat", 32'(csr_tg_stat), 32'h0);
        chk("reset_start", 32'(tg_start), 32'h0);

        // Basic pass on channel 0
        step(1, 1, 4'b1110, '0, '0, '0);
        chk("basic_start", 32'(tg_start[0]), 32'h1);
        chk("basic_active", 32'(csr_tg_stat[3:0]), 32'h1);
        chk("basic_others", 32'(csr_tg_stat[15:4]), 32'h0);
        step(1, 0, '1, 4'b0001, '0, '0);
        idle(9);
        step(1, 0, '1, '0, 4'b0001, '0);
        chk("basic_pass", 32'(csr_tg_stat[3:0]), 32'h8);

        // Fail with ready stall on channel 2
        cnt = 0;
        step(1, 1, 4'b1011, '0, '0, '0);
        cnt += int'(tg_start[2]);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, '1, '0, '0, '0);
            cnt += int'(tg_start[2]);
        end
        step(1, 0, '1, 4'b0100, '0, '0);
        cnt += int'(tg_start[2]);
        chk("stall_start_len", 32'(cnt), 32'd6);
        step(1, 0, '1, '0, 4'b0100, 4'b0100);
        chk("stall_fail", 32'(csr_tg_stat[11:8]), 32'h4);

        // Timeout on channel 1
        ab_cnt = 0; ab_at = -1;
        step(1, 1, 4'b1101, '0, '0, '0);
        for (int k = 1; k <= 22; k++) begin
            if (k == 1) step(1, 0, '1, 4'b0010, '0, '0);
            else        step(1, 0, '1, '0, '0, '0);
            if (tg_abort[1]) begin ab_cnt++; ab_at = k; end
        end
        chk("to_abort_count", 32'(ab_cnt), 32'd1);
        chk("to_abort_cycle", 32'(ab_at), 32'd16);
        chk("to_stat", 32'(csr_tg_stat[7:4]), 32'h2);

        // Done on the deadline cycle on channel 3
        ab_cnt = 0;
        step(1, 1, 4'b0111, '0, '0, '0);
        step(1, 0, '1, 4'b1000, '0, '0);
        for (int k = 2; k <= 15; k++) begin
            step(1, 0, '1, '0, '0, '0);
            ab_cnt += int'(tg_abort[3]);
        end
        step(1, 0, '1, '0, 4'b1000, '0);
        ab_cnt += int'(tg_abort[3]);
        idle(2);
        ab_cnt += int'(tg_abort[3]);
        chk("sim_stat", 32'(csr_tg_stat[15:12]), 32'h8);
        chk("sim_no_abort", 32'(ab_cnt), 32'd0);

        // Ignored write while running, relaunch after done, reset mid-run
        step(1, 1, 4'b1110, '0, '0, '0);
        step(1, 0, '1, 4'b0001, '0, '0);
        step(1, 1, 4'b1110, '0, '0, '0);
        chk("ignored_write", 32'(tg_start[0]), 32'h0);
        step(1, 0, '1, '0, 4'b0001, '0);
        chk("rerun_pass", 32'(csr_tg_stat[3:0]), 32'h8);
        step(1, 1, 4'b1110, '0, '0, '0);
        chk("relaunch", 32'(csr_tg_stat[3:0]), 32'h1);
        step(1, 0, '1, 4'b0001, '0, '0);
        idle(2);
        step(0, 0, '1, '0, '0, '0);
        chk("rst_stat", 32'(csr_tg_stat), 32'h0);
        chk("rst_abort", 32'(tg_abort), 32'h0);
        chk("rst_start", 32'(tg_start), 32'h0);

        // All channels in parallel
        step(1, 1, 4'b0000, '0, '0, '0);
        step(1, 0, '1, 4'b1011, '0, '0);
        step(1, 0, '1, '0, 4'b0001, '0);
        idle(2);
        step(1, 0, '1, '0, 4'b0010, 4'b0010);
        idle(3);
        step(1, 0, '1, '0, 4'b1000, '0);
        idle(12);
        chk("par_stat", 32'(csr_tg_stat), 32'h8248);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 5) == 0),
                 4'($urandom),
                 4'($urandom),
                 {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)},
                 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
